kronos_data_bus: RTL and testbench

- Parametrised data-side interconnect between the kronos_core data port (data_req/data_ack handshake) and NUM_SLAVES memory-mapped targets: data RAM, LED/HEX registers, switch/key inputs, timer.
- Successor to the fixed top-level wiring, where only instruction ROM is connected and the data port is left unserviced.
- Adds address decode, one outstanding transaction, per-access timeout and bus-error reporting.

---
 rtl/kronos_data_bus.sv | 186 ++++++++++++++++++
 tb/tb_kronos_data_bus.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/kronos_data_bus.sv
// kronos_data_bus: data-port interconnect between the kronos core and a set of
// memory-mapped slaves. One transaction in flight, lowest-index address decode,
// per-access timeout, and bus-error reporting (error address + saturating count).
module kronos_data_bus #(
    parameter int                         NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {NUM_SLAVES{32'hFFFFF000}},
    parameter int                         TIMEOUT    = 255,
    parameter logic [31:0]                ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      rstz,
    input  logic [31:0]               data_addr,
    input  logic [31:0]               data_wr_data,
    input  logic [3:0]                data_mask,
    input  logic                      data_wr_en,
    input  logic                      data_req,
    output logic                      data_ack,
    output logic [31:0]               data_rd_data,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wr_data,
    output logic [3:0]                s_mask,
    output logic                      s_wr_en,
    output logic [NUM_SLAVES-1:0]     s_req,
    input  logic [NUM_SLAVES-1:0]     s_ack,
    input  logic [NUM_SLAVES*32-1:0]  s_rd_data,
    output logic                      bus_err,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_count
);

    // Timeout counter only needs to reach TIMEOUT-1 before the abort fires.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             s_addr_q, s_addr_d;
    logic [31:0]             s_wr_data_q, s_wr_data_d;
    logic [3:0]              s_mask_q, s_mask_d;
    logic                    s_wr_en_q, s_wr_en_d;
    logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    ack_q, ack_d;
    logic [31:0]             rd_q, rd_d;
    logic                    berr_q, berr_d;
    logic [31:0]             err_addr_q, err_addr_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic                    hit;
    logic [NUM_SLAVES-1:0]   hit_oh;
    logic                    ack_sel;
    logic [31:0]             ack_data;

    // Address decode: walk from the top so the lowest matching index wins.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((data_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // Only the selected slave's ack and read data are observed.
    always_comb begin
        ack_sel  = |(s_ack & s_req_q);
        ack_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_req_q[i]) ack_data = s_rd_data[i*32 +: 32];
        end
    end

    // Next-state and registered-output logic; response outputs are loaded on the
    // transition into RESP so they appear during the RESP cycle.
    always_comb begin
        state_d     = state_q;
        s_addr_d    = s_addr_q;
        s_wr_data_d = s_wr_data_q;
        s_mask_d    = s_mask_q;
        s_wr_en_d   = s_wr_en_q;
        s_req_d     = s_req_q;
        tmo_d       = tmo_q;
        ack_d       = 1'b0;
        berr_d      = 1'b0;
        rd_d        = rd_q;
        err_addr_d  = err_addr_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    s_addr_d    = data_addr;
                    s_wr_data_d = data_wr_data;
                    s_mask_d    = data_mask;
                    s_wr_en_d   = data_wr_en;
                    tmo_d       = '0;
                    if (hit) begin
                        s_req_d = hit_oh;
                        state_d = ACCESS;
                    end else begin
                        // Decode miss: nobody sees the access, answer with an error.
                        ack_d      = 1'b1;
                        berr_d     = 1'b1;
                        rd_d       = ERR_DATA;
                        err_addr_d = data_addr;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        state_d    = RESP;
                    end
                end
            end
            ACCESS: begin
                if (ack_sel) begin
                    // A slave ack beats a simultaneous timeout.
                    s_req_d = '0;
                    ack_d   = 1'b1;
                    rd_d    = ack_data;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    s_req_d    = '0;
                    ack_d      = 1'b1;
                    berr_d     = 1'b1;
                    rd_d       = ERR_DATA;
                    err_addr_d = s_addr_q;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d    = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                s_req_d = '0;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= IDLE;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
            s_mask_q    <= '0;
            s_wr_en_q   <= 1'b0;
            s_req_q     <= '0;
            tmo_q       <= '0;
            ack_q       <= 1'b0;
            berr_q      <= 1'b0;
            rd_q        <= '0;
            err_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_addr_q    <= s_addr_d;
            s_wr_data_q <= s_wr_data_d;
            s_mask_q    <= s_mask_d;
            s_wr_en_q   <= s_wr_en_d;
            s_req_q     <= s_req_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            berr_q      <= berr_d;
            rd_q        <= rd_d;
            err_addr_q  <= err_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign data_ack     = ack_q;
    assign data_rd_data = rd_q;
    assign s_addr       = s_addr_q;
    assign s_wr_data    = s_wr_data_q;
    assign s_mask       = s_mask_q;
    assign s_wr_en      = s_wr_en_q;
    assign s_req        = s_req_q;
    assign bus_err      = berr_q;
    assign err_addr     = err_addr_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_kronos_data_bus.sv
// Bench for kronos_data_bus: directed transactions, a transaction-level model that
// predicts every output per cycle from the latency rules, and literal pin checks.
module tb_kronos_data_bus;

    localparam int NS  = 4;
    localparam int TMO = 8;
    localparam logic [NS*32-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_F000};

    logic              clk, rstz;
    logic [31:0]       data_addr, data_wr_data, data_rd_data;
    logic [3:0]        data_mask, s_mask;
    logic              data_wr_en, data_req, data_ack;
    logic [31:0]       s_addr, s_wr_data, err_addr;
    logic              s_wr_en, bus_err;
    logic [NS-1:0]     s_req, s_ack;
    logic [NS*32-1:0]  s_rd_data;
    logic [7:0]        err_count;

    kronos_data_bus #(
        .NUM_SLAVES(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
        .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .rstz(rstz),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack),
        .data_rd_data(data_rd_data),
        .s_addr(s_addr), .s_wr_data(s_wr_data), .s_mask(s_mask), .s_wr_en(s_wr_en),
        .s_req(s_req), .s_ack(s_ack), .s_rd_data(s_rd_data),
        .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int berr_seen = 0;
    bit chk_en = 1'b0;

    // Model of the bus outputs for the current cycle.
    logic [31:0]   e_rd, e_eaddr, e_saddr, e_swd;
    logic [7:0]    e_ecnt;
    logic [3:0]    e_smask;
    logic          e_swe, e_ack, e_berr;
    logic [NS-1:0] e_sreq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Which slave an address targets: lowest index whose window contains it, -1 if none.
    function automatic int target(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) return i;
        return -1;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_ack",     32'(data_ack),  32'(e_ack));
            chk("bus_err",      32'(bus_err),   32'(e_berr));
            chk("data_rd_data", data_rd_data,   e_rd);
            chk("s_req",        32'(s_req),     32'(e_sreq));
            chk("s_addr",       s_addr,         e_saddr);
            chk("s_wr_data",    s_wr_data,      e_swd);
            chk("s_mask",       32'(s_mask),    32'(e_smask));
            chk("s_wr_en",      32'(s_wr_en),   32'(e_swe));
            chk("err_addr",     err_addr,       e_eaddr);
            chk("err_count",    32'(err_count), 32'(e_ecnt));
            if (bus_err) berr_seen++;
        end
    end

    task automatic model_reset();
        e_rd = '0; e_eaddr = '0; e_saddr = '0; e_swd = '0; e_ecnt = '0;
        e_smask = '0; e_swe = 1'b0; e_ack = 1'b0; e_berr = 1'b0; e_sreq = '0;
    endtask

    task automatic idle(input int k);
        data_req = 1'b0; s_ack = '0;
        e_ack = 1'b0; e_berr = 1'b0; e_sreq = '0;
        for (int c = 0; c < k; c++) begin
            @(posedge clk); #1;
        end
    endtask

    // One core transaction. ack_after = s_req cycle in which the target slave acks
    // (1 = first s_req cycle, 0 = never). noise: other slaves ack every cycle and the
    // target also acks while the bus is in IDLE/RESP; all of that must be ignored.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] m,
                          input logic we, input int ack_after, input logic [31:0] rdv,
                          input bit noise);
        int t, n;
        bit err;
        logic [NS-1:0] oh;
        t = target(addr);
        if (t < 0) begin n = 0; err = 1'b1; end
        else if (ack_after >= 1 && ack_after <= TMO) begin n = ack_after; err = 1'b0; end
        else begin n = TMO; err = 1'b1; end
        oh = (t < 0) ? '0 : NS'(1) << t;
        for (int c = 0; c <= n + 1; c++) begin
            data_req = 1'b1; data_addr = addr; data_wr_data = wd;
            data_mask = m; data_wr_en = we;
            s_ack = noise ? ~oh : '0;
            if (noise && (c == 0 || c == n + 1)) s_ack = s_ack | oh;
            for (int i = 0; i < NS; i++) s_rd_data[i*32 +: 32] = {16'hBAD0, 8'(c), 8'(i)};
            if (t >= 0 && !err && c == n) begin
                s_ack[t] = 1'b1;
                s_rd_data[t*32 +: 32] = rdv;
            end
            if (c == 1) begin e_saddr = addr; e_swd = wd; e_smask = m; e_swe = we; end
            e_sreq = (c >= 1 && c <= n) ? oh : '0;
            e_ack  = (c == n + 1);
            e_berr = err && (c == n + 1);
            if (c == n + 1) begin
                e_rd = err ? 32'hDEADBEEF : rdv;
                if (err) begin
                    e_eaddr = addr;
                    if (e_ecnt != 8'hFF) e_ecnt = e_ecnt + 8'd1;
                end
            end
            @(posedge clk); #1;
        end
        data_req = 1'b0; s_ack = '0;
        e_ack = 1'b0; e_berr = 1'b0; e_sreq = '0;
    endtask

    initial begin
        rstz = 1'b0; data_addr = '0; data_wr_data = '0; data_mask = '0;
        data_wr_en = 1'b0; data_req = 1'b0; s_ack = '0; s_rd_data = '0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst data_ack", 32'(data_ack), 32'd0);
        chk("rst s_req", 32'(s_req), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        rstz = 1'b1;
        idle(2);

        // Immediate-ack read from slave 0.
        do_txn(32'h0000_0010, 32'h0, 4'hF, 1'b0, 1, 32'h1234_5678, 1'b0);
        chk("pin rd slave0", data_rd_data, 32'h1234_5678);

        // Write to slave 1 acking in its 4th s_req cycle, with ack noise; back-to-back into a miss.
        do_txn(32'h1000_0004, 32'h0000_00A5, 4'b0001, 1'b1, 4, 32'h0000_0777, 1'b1);
        chk("pin s_addr wr", s_addr, 32'h1000_0004);
        chk("pin s_mask wr", 32'(s_mask), 32'd1);
        chk("pin s_wr_en wr", 32'(s_wr_en), 32'd1);

        // Unmapped read.
        do_txn(32'h3000_0000, 32'h0, 4'hF, 1'b0, 1, 32'h0, 1'b1);
        chk("pin miss rdata", data_rd_data, 32'hDEADBEEF);
        chk("pin miss err_addr", err_addr, 32'h3000_0000);
        chk("pin miss err_count", 32'(err_count), 32'd1);
        idle(1);

        // Overlapping windows: slave 2 wins; then a timeout on slave 2.
        do_txn(32'h2000_0004, 32'h0, 4'hF, 1'b0, 2, 32'hCAFE_0002, 1'b1);
        do_txn(32'h2000_0008, 32'h0, 4'hF, 1'b0, 0, 32'h0, 1'b0);
        chk("pin tmo err_addr", err_addr, 32'h2000_0008);
        chk("pin tmo err_count", 32'(err_count), 32'd2);

        // Ack in the last allowed cycle beats the timeout.
        do_txn(32'h2000_000C, 32'h0, 4'hF, 1'b0, TMO, 32'h8888_8888, 1'b0);
        chk("pin late ack rdata", data_rd_data, 32'h8888_8888);
        chk("pin late ack count", 32'(err_count), 32'd2);
        idle(1);

        // Reset in the middle of an ACCESS.
        data_req = 1'b1; data_addr = 32'h0000_0020; data_wr_data = '0;
        data_mask = 4'hF; data_wr_en = 1'b0; s_ack = '0;
        @(posedge clk); #1;
        e_saddr = 32'h0000_0020; e_swd = '0; e_smask = 4'hF; e_swe = 1'b0; e_sreq = 4'b0001;
        @(posedge clk); #1;
        rstz = 1'b0;
        model_reset();
        #1;
        chk("rst mid s_req", 32'(s_req), 32'd0);
        chk("rst mid err_count", 32'(err_count), 32'd0);
        chk("rst mid data_ack", 32'(data_ack), 32'd0);
        idle(3);
        rstz = 1'b1;
        idle(1);
        do_txn(32'h0000_0044, 32'h0, 4'hF, 1'b0, 2, 32'h5A5A_5A5A, 1'b0);
        chk("pin post-rst rdata", data_rd_data, 32'h5A5A_5A5A);

        // Error counter saturation.
        berr_seen = 0;
        for (int k = 0; k < 260; k++)
            do_txn(32'h4000_0000 + 32'(k * 4), 32'h0, 4'hF, 1'b0, 1, 32'h0, 1'b0);
        chk("pin sat err_count", 32'(err_count), 32'd255);
        chk("pin sat bus_err pulses", 32'(berr_seen), 32'd260);
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
